// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared types and helpers for the sequential adder/subtractor.
//                Holds the FSM state encoding, the operation codes and the
//                chunk-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Counter width for n chunks; never below one bit so a single-chunk
    // configuration still has a legal counter vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/FullAdder.sv
`default_nettype none
// ============================================================================
//  Module      : FullAdder
//  Description : Single-bit full adder cell.
//  Ports       : a_i, b_i, ci_i  - addend bits and carry in
//                s_o, co_o       - sum bit and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module FullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule : FullAdder
`default_nettype wire

// File: rtl/addsub_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_chunk
//  Description : Combinational W-bit ripple adder built from FullAdder cells.
//  Ports       : a_i, b_i      - W-bit addends
//                cin_i         - carry into bit 0
//                sum_o         - W-bit sum
//                cout_o        - carry out of the top bit
//                c_msb_in_o    - carry into the top bit (for signed overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         c_msb_in_o
);

    logic [W:0] w_c;

    assign w_c[0] = cin_i;

    generate
        for (genvar i = 0; i < W; i++) begin : g_fa
            FullAdder u_fa (
                .a_i  (a_i[i]),
                .b_i  (b_i[i]),
                .ci_i (w_c[i]),
                .s_o  (sum_o[i]),
                .co_o (w_c[i+1])
            );
        end
    endgenerate

    assign cout_o     = w_c[W];
    assign c_msb_in_o = w_c[W-1];

endmodule : addsub_chunk
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : seq_addsub
//  Description : Multi-cycle adder/subtractor. Adds CHUNK bits per clock,
//                rippling the carry between chunks through a register, with
//                valid/ready handshakes on both sides.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                in_valid_i/in_ready_o       - operand handshake
//                a_i, b_i, sub_i             - operands, 0 = A+B, 1 = A-B
//                out_valid_o/out_ready_i     - result handshake
//                result_o                    - sum/difference mod 2^WIDTH
//                carry_out_o                 - MSB carry (1 = no borrow on sub)
//                overflow_o                  - signed overflow
//                zero_o                      - result is all zeros
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int              NCHUNK = WIDTH / CHUNK;
    localparam int              CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    addsub_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             carry_q, cout_q, ovf_q, zero_q;

    logic [CHUNK-1:0] w_a_chunk, w_b_chunk, w_sum;
    logic             w_cout, w_cmsb;
    logic [WIDTH-1:0] w_result_next;
    logic             w_last;

    assign w_last = (cnt_q == LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i)  state_d = RUN;
            RUN:     if (w_last)      state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
    end

    // Select the operand chunk addressed by the counter.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                w_a_chunk = a_q[k*CHUNK +: CHUNK];
                w_b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    addsub_chunk #(.W(CHUNK)) u_chunk (
        .a_i        (w_a_chunk),
        .b_i        (w_b_chunk),
        .cin_i      (carry_q),
        .sum_o      (w_sum),
        .cout_o     (w_cout),
        .c_msb_in_o (w_cmsb)
    );

    // Merge the fresh chunk into the result; also feeds the zero flag so the
    // last chunk is included without waiting a cycle.
    always_comb begin
        w_result_next = result_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CNT_W'(k)) w_result_next[k*CHUNK +: CHUNK] = w_sum;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= a_i;
                        // Subtraction is A + ~B + 1: invert B, seed carry.
                        b_q     <= b_i ^ {WIDTH{sub_i == OP_SUB}};
                        carry_q <= (sub_i == OP_SUB);
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    result_q <= w_result_next;
                    carry_q  <= w_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (w_last) begin
                        cout_q <= w_cout;
                        ovf_q  <= w_cmsb ^ w_cout;
                        zero_q <= (w_result_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o    = result_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;
    assign zero_o      = zero_q;

endmodule : seq_addsub
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_addsub
//  Description : Self-checking bench for seq_addsub. Three instances share a
//                clock and reset: CHUNK=4 (index 0), CHUNK=16 (index 1) and
//                CHUNK=1 (index 2), all WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] a         [3];
    logic [15:0] b         [3];
    logic        sub       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] res       [3];
    logic        cout      [3];
    logic        ovf       [3];
    logic        zro       [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .a_i(a[0]), .b_i(b[0]), .sub_i(sub[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .result_o(res[0]), .carry_out_o(cout[0]),
        .overflow_o(ovf[0]), .zero_o(zro[0])
    );

    seq_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .a_i(a[1]), .b_i(b[1]), .sub_i(sub[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .result_o(res[1]), .carry_out_o(cout[1]),
        .overflow_o(ovf[1]), .zero_o(zro[1])
    );

    seq_addsub #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .a_i(a[2]), .b_i(b[2]), .sub_i(sub[2]),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .result_o(res[2]), .carry_out_o(cout[2]),
        .overflow_o(ovf[2]), .zero_o(zro[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                  output logic [15:0] r, output logic c,
                                  output logic o, output logic z);
        int ux, uy, sx, sy, us, ss;
        ux = int'(x);           uy = int'(y);
        sx = int'($signed(x));  sy = int'($signed(y));
        us = s ? (ux - uy) : (ux + uy);
        ss = s ? (sx - sy) : (sx + sy);
        r  = us[15:0];
        c  = s ? (ux >= uy) : (us > 65535);
        o  = (ss > 32767) || (ss < -32768);
        z  = (r == 16'h0000);
    endfunction

    // One complete transaction: accept, wait for out_valid, check, hand off.
    task automatic run_op(input int idx, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input int lat, input string tag);
        logic [15:0] er;
        logic ec, eo, ez, rdy_seen;
        int n;
        model(x, y, s, er, ec, eo, ez);
        @(negedge clk);
        chk({tag, " in_ready_idle"}, in_ready[idx], 1);
        a[idx] = x; b[idx] = y; sub[idx] = s; in_valid[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        // Operands may change freely once accepted.
        a[idx] = 16'($urandom); b[idx] = 16'($urandom); sub[idx] = 1'($urandom);
        n = 0;
        rdy_seen = in_ready[idx];
        while (!out_valid[idx] && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!out_valid[idx]) rdy_seen = rdy_seen | in_ready[idx];
        end
        rdy_seen = rdy_seen | in_ready[idx];
        chk({tag, " latency"}, n, lat);
        chk({tag, " in_ready_busy"}, rdy_seen, 0);
        chk({tag, " result"}, res[idx], er);
        chk({tag, " carry_out"}, cout[idx], ec);
        chk({tag, " overflow"}, ovf[idx], eo);
        chk({tag, " zero"}, zro[idx], ez);
        @(negedge clk);
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
        chk({tag, " out_valid_drop"}, out_valid[idx], 0);
        chk({tag, " in_ready_back"}, in_ready[idx], 1);
    endtask

    initial begin
        logic [15:0] er, hold_r;
        logic ec, eo, ez;
        logic seen;
        int lat_of[3];
        lat_of[0] = 4; lat_of[1] = 1; lat_of[2] = 16;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0;
            a[i] = '0; b[i] = '0; sub[i] = 1'b0;
        end

        // Reset state on all instances.
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset result", res[i], 0);
            chk("reset flags", {cout[i], ovf[i], zro[i]}, 0);
            chk("reset out_valid", out_valid[i], 0);
            chk("reset in_ready", in_ready[i], 1);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases on CHUNK=4.
        run_op(0, 16'h1234, 16'h0FFF, 1'b0, 4, "add_basic");
        run_op(0, 16'h0005, 16'h0005, 1'b1, 4, "sub_equal");
        run_op(0, 16'h0003, 16'h0005, 1'b1, 4, "sub_borrow");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 4, "add_ovf");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 4, "add_wrap");
        run_op(0, 16'h8000, 16'h0001, 1'b1, 4, "sub_ovf");
        // Spot-check the absolute expectations for the first case as well.
        model(16'h1234, 16'h0FFF, 1'b0, er, ec, eo, ez);
        chk("model add_basic", {er, ec, eo, ez}, {16'h2233, 3'b000});

        // Backpressure: hold result in DONE for five cycles.
        model(16'hA5A5, 16'h1111, 1'b1, er, ec, eo, ez);
        @(negedge clk);
        a[0] = 16'hA5A5; b[0] = 16'h1111; sub[0] = 1'b1; in_valid[0] = 1'b1;
        @(negedge clk); in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp out_valid", out_valid[0], 1);
        hold_r = res[0];
        chk("bp result", hold_r, er);
        for (int i = 0; i < 5; i++) begin
            a[0] = 16'($urandom); b[0] = 16'($urandom); in_valid[0] = 1'b1;
            @(posedge clk); #1;
            chk("bp hold result", res[0], er);
            chk("bp hold flags", {cout[0], ovf[0], zro[0]}, {ec, eo, ez});
            chk("bp hold valid", out_valid[0], 1);
            chk("bp in_ready", in_ready[0], 0);
            @(negedge clk); in_valid[0] = 1'b0;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("bp release valid", out_valid[0], 0);
        chk("bp release ready", in_ready[0], 1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp no ghost op", out_valid[0], 0);
        chk("bp result kept", res[0], er);

        // Reset in the middle of RUN.
        @(negedge clk);
        a[0] = 16'h4321; b[0] = 16'h1111; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1; in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        chk("rst async result", res[0], 0);
        chk("rst async flags", {cout[0], ovf[0], zro[0]}, 0);
        chk("rst async in_ready", in_ready[0], 1);
        chk("rst async out_valid", out_valid[0], 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | out_valid[0];
        end
        chk("rst no out_valid", seen, 0);
        run_op(0, 16'h0001, 16'h0001, 1'b0, 4, "post_rst");

        // Randomised sweep on each configuration.
        for (int i = 0; i < 200; i++)
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), lat_of[0], "rnd_c4");
        for (int i = 0; i < 1000; i++)
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), lat_of[1], "rnd_c16");
        for (int i = 0; i < 1000; i++)
            run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), lat_of[2], "rnd_c1");
        // Boundary operands on the two extreme chunkings.
        for (int d = 1; d < 3; d++) begin
            run_op(d, 16'hFFFF, 16'h0001, 1'b0, lat_of[d], "edge_wrap");
            run_op(d, 16'h8000, 16'h0001, 1'b1, lat_of[d], "edge_sub_ovf");
            run_op(d, 16'h7FFF, 16'h0001, 1'b0, lat_of[d], "edge_add_ovf");
            run_op(d, 16'h0000, 16'h0000, 1'b1, lat_of[d], "edge_zero_sub");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_addsub
`default_nettype wire

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry between chunks through a registered carry bit. Valid/ready handshakes on the input and output sides let it sit between operand-producing and result-consuming stages of the datapath. It reports the unsigned carry/borrow, signed overflow and zero flags.

Parameters:
WIDTH, 16, operand and result width in bits.
CHUNK, 4, bits added per cycle. WIDTH % CHUNK != 0 is an elaboration error. NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and op are valid.
in_ready  output  1  block can accept an operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  sum or difference, modulo 2^WIDTH.
carry_out  output  1  carry out of the MSB. For subtraction, 1 = no borrow (A >= B unsigned).
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
zero  output  1  result == 0.

Behaviour:
- Reset (async assert, state updated on clk after deassert):
  - state = IDLE, out_valid = 0, result = 0, carry_out = 0, overflow = 0, zero = 0.
  - Chunk counter = 0, internal carry = 0.
- States are IDLE, RUN and DONE.
- in_ready = (state == IDLE). It is combinational from state.
- out_valid = (state == DONE), registered via state.
- IDLE:
  - On in_valid && in_ready at edge T, latch a, b ^ {WIDTH{sub}}, and carry = sub. Clear the counter and go to RUN.
- RUN:
  - Each edge adds chunk k = counter of the latched A and the latched, inverted-if-sub B, plus the registered carry.
  - Writes that chunk into result[k*CHUNK +: CHUNK], updates the carry and increments the counter.
  - On the last chunk (counter == NCHUNK-1), also capture the MSB carry-in and carry-out, compute overflow, carry_out and zero, and go to DONE.
  - Net effect: RUN lasts exactly NCHUNK cycles, and out_valid rises at edge T+NCHUNK.
- DONE:
  - Hold result and flags stable while out_ready = 0.
  - On out_ready go to IDLE, and out_valid drops at the next edge.
  - Result and flags keep their last value in IDLE.
- in_valid is ignored outside IDLE. No input is accepted in the same cycle as an output handshake, so throughput is 1 op per NCHUNK+2 cycles.
- Operands are sampled only at acceptance. Input changes during RUN/DONE have no effect.
- result is partially updated during RUN and is not meaningful until out_valid.
- Reset asserted mid-RUN or in DONE aborts immediately to reset values. The operation is lost and no out_valid is produced.
- CHUNK == WIDTH is legal: one RUN cycle, latency 1 cycle from accept to out_valid.
- Zero flag: 1 for an all-zero result regardless of carry (e.g. 0xFFFF+0x0001 gives zero = 1, carry_out = 1).

Decomposition:
- Package addsub_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;
  - localparam OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - a function clog2-safe counter width helper, CNT_W = max(1, $clog2(NCHUNK)).
- One sub-module, addsub_chunk: parametrised (W = CHUNK) combinational ripple adder.
  - Inputs: a, b, cin. Outputs: sum, cout, and c_msb_in, the carry into its top bit, used for overflow.
  - It is built as a chain of the existing FullAdder cells.
- The top level holds the FSM, counter, operand and carry registers, and the flag logic.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4 unless noted.
1. Add 0x1234 + 0x0FFF, sub=0 -> result 0x2233, carry_out 0, overflow 0, zero 0. out_valid rises exactly 4 cycles after the accept edge, and in_ready is 0 throughout.
2. Subtract 0x0005 - 0x0005 -> result 0x0000, zero 1, carry_out 1, overflow 0. Then subtract 0x0003 - 0x0005 -> result 0xFFFE, carry_out 0, overflow 0, zero 0.
3. Overflow cases:
   - 0x7FFF + 0x0001 -> 0x8000, overflow 1, carry_out 0.
   - 0xFFFF + 0x0001 -> 0x0000, carry_out 1, zero 1, overflow 0.
   - 0x8000 - 0x0001 -> 0x7FFF, overflow 1, carry_out 1.
4. Backpressure: hold out_ready = 0 for 5 cycles in DONE. result and flags stay stable, in_ready stays 0, and in_valid pulses with new operands are ignored. Release out_ready -> IDLE next edge, in_ready = 1.
5. Reset mid-operation: assert rst_n = 0 after 2 RUN cycles. Outputs go to reset values asynchronously, in_ready reads 1, and out_valid never asserts. A fresh 0x0001 + 0x0001 afterwards yields 0x0002.
6. Parameter sweep CHUNK=16 and CHUNK=1 with random operands (1000 each, both ops) -> result and flags match the reference model. Latency is 1 and 16 cycles respectively.
